// File: rtl/chicken_pkg.sv
// chicken_pkg: shared constants for the chicken track plus the turn_ctrl state encoding.
package chicken_pkg;

  localparam int unsigned TRACK_LEN   = 24;
  localparam int unsigned POS_W       = 5;
  localparam int unsigned MAX_PLAYERS = 4;

  typedef enum logic [1:0] {
    WAIT   = 2'd0,
    STEP   = 2'd1,
    SETTLE = 2'd2,
    PASS   = 2'd3
  } turn_state_e;

  // Clamp the raw player count into the supported 2..4 range.
  function automatic logic [2:0] eff_players(logic [3:0] n);
    if (n < 4'd2) return 3'd2;
    if (n > 4'd4) return 3'd4;
    return n[2:0];
  endfunction

endpackage

// File: rtl/turn_ctrl_if.sv
// turn_ctrl_if: card handshake, player positions and advance/turn outputs of turn_ctrl.
// master = card source / position provider, slave = turn_ctrl.
interface turn_ctrl_if
  import chicken_pkg::*;
#(
  parameter int unsigned PW = POS_W
);

  logic [3:0]    N;
  logic          card_valid;
  logic          card_match;
  logic          card_ready;
  logic [PW-1:0] pos0;
  logic [PW-1:0] pos1;
  logic [PW-1:0] pos2;
  logic [PW-1:0] pos3;
  logic [3:0]    p_da;
  logic [1:0]    turn;
  logic          busy;

  modport master (
    output N, card_valid, card_match, pos0, pos1, pos2, pos3,
    input  card_ready, p_da, turn, busy
  );

  modport slave (
    input  N, card_valid, card_match, pos0, pos1, pos2, pos3,
    output card_ready, p_da, turn, busy
  );

endinterface

// File: rtl/hop_calc.sv
// hop_calc: combinational hop count for the current player. A move covers one tile plus
// every consecutive tile directly ahead that another active chicken is standing on.
module hop_calc
  import chicken_pkg::*;
#(
  parameter int unsigned TRACK = TRACK_LEN,
  parameter int unsigned PW    = POS_W
) (
  input  logic [MAX_PLAYERS-1:0][PW-1:0] pos,
  input  logic [1:0]                     turn,
  input  logic [2:0]                     neff,
  output logic [2:0]                     hops
);

  logic [PW:0]            base;
  logic [PW:0]            tile [MAX_PLAYERS-1];
  logic [MAX_PLAYERS-2:0] occ;
  logic                   run;

  assign base = {1'b0, pos[turn]};

  // Tiles 1..3 ahead, wrapped with a single conditional subtract.
  for (genvar j = 0; j < MAX_PLAYERS - 1; j++) begin : g_tile
    logic [PW:0] sum;
    assign sum     = base + (PW+1)'(j + 1);
    assign tile[j] = (sum >= (PW+1)'(TRACK)) ? sum - (PW+1)'(TRACK) : sum;
  end

  // A tile is occupied by any other active player with an on-track position.
  always_comb begin
    occ = '0;
    for (int j = 0; j < int'(MAX_PLAYERS) - 1; j++) begin
      for (int i = 0; i < int'(MAX_PLAYERS); i++) begin
        if (i != int'(turn) && i < int'(neff) && pos[i] < PW'(TRACK) &&
            {1'b0, pos[i]} == tile[j]) begin
          occ[j] = 1'b1;
        end
      end
    end
  end

  // Count the unbroken run of occupied tiles starting right ahead.
  always_comb begin
    run  = 1'b1;
    hops = 3'd1;
    for (int j = 0; j < int'(MAX_PLAYERS) - 1; j++) begin
      run  = run & occ[j];
      hops = hops + {2'b00, run};
    end
  end

endmodule

// File: rtl/turn_ctrl.sv
// turn_ctrl: turn sequencer for the 24-tile chicken track. A matching card becomes a burst
// of one-cycle advance pulses for the current player; a mismatch passes the turn on.
// Optional feature: define TURN_TIMEOUT_EN to force a turn pass after TIMEOUT idle cycles.
module turn_ctrl
  import chicken_pkg::*;
#(
  parameter int unsigned TRACK   = TRACK_LEN,
  parameter int unsigned PW      = POS_W,
  parameter int unsigned TIMEOUT = 1000
) (
  input logic        B,
  input logic        rst,
  turn_ctrl_if.slave bus
);

  turn_state_e state_q, state_d;
  logic [1:0]  turn_q, turn_d, turn_eff;
  logic [2:0]  step_q, step_d;
  logic [2:0]  hops, neff;
  logic        ready_q, busy_q;
  logic [3:0]  p_da_q;
  logic        accept;
  logic        timeout;
  logic [MAX_PLAYERS-1:0][PW-1:0] pos_all;

  assign neff     = eff_players(bus.N);
  // A turn index beyond the live player count is treated as player 0.
  assign turn_eff = ({1'b0, turn_q} >= neff) ? 2'd0 : turn_q;
  assign accept   = bus.card_valid & ready_q;
  assign pos_all  = {bus.pos3, bus.pos2, bus.pos1, bus.pos0};

  hop_calc #(
    .TRACK (TRACK),
    .PW    (PW)
  ) u_hop_calc (
    .pos  (pos_all),
    .turn (turn_eff),
    .neff (neff),
    .hops (hops)
  );

`ifdef TURN_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] to_q, to_d;

  assign timeout = (to_q == TW'(TIMEOUT - 1));

  // Idle counter for WAIT; an accepted card clears it, so a card on the timeout cycle wins.
  always_comb begin
    to_d = to_q;
    if (state_q == WAIT) begin
      if (accept || timeout) begin
        to_d = '0;
      end else begin
        to_d = to_q + TW'(1);
      end
    end
  end

  // Idle counter register.
  always_ff @(posedge B or negedge rst) begin
    if (!rst) begin
      to_q <= '0;
    end else begin
      to_q <= to_d;
    end
  end
`else
  logic unused_timeout;
  assign timeout        = 1'b0;
  assign unused_timeout = (TIMEOUT != 0);
`endif

  // Next-state, turn and step-count logic.
  always_comb begin
    state_d = state_q;
    turn_d  = turn_q;
    step_d  = step_q;
    unique case (state_q)
      WAIT: begin
        turn_d = turn_eff;
        if (accept) begin
          if (bus.card_match) begin
            state_d = STEP;
            step_d  = hops;
          end else begin
            state_d = PASS;
          end
        end else if (timeout) begin
          state_d = PASS;
        end
      end
      STEP: begin
        step_d = step_q - 3'd1;
        if (step_q <= 3'd1) state_d = SETTLE;
      end
      SETTLE: state_d = WAIT;
      PASS: begin
        turn_d  = ({1'b0, turn_q} + 3'd1 >= neff) ? 2'd0 : turn_q + 2'd1;
        state_d = WAIT;
      end
      default: state_d = WAIT;
    endcase
  end

  // State, turn and step-count registers.
  always_ff @(posedge B or negedge rst) begin
    if (!rst) begin
      state_q <= WAIT;
      turn_q  <= 2'd0;
      step_q  <= 3'd0;
    end else begin
      state_q <= state_d;
      turn_q  <= turn_d;
      step_q  <= step_d;
    end
  end

  // Registered outputs decoded from the upcoming state so they line up with it.
  always_ff @(posedge B or negedge rst) begin
    if (!rst) begin
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      p_da_q  <= 4'b0000;
    end else begin
      ready_q <= (state_d == WAIT);
      busy_q  <= (state_d == STEP) || (state_d == SETTLE);
      p_da_q  <= (state_d == STEP) ? (4'b0001 << turn_d) : 4'b0000;
    end
  end

  assign bus.card_ready = ready_q;
  assign bus.busy       = busy_q;
  assign bus.p_da       = p_da_q;
  assign bus.turn       = turn_q;

endmodule

// File: doc/turn_ctrl.md
Name: turn_ctrl

Overview:
- Upstream sequencer for the per-player position counters on the 24-tile track.
- Owns whose turn it is among N players (2..4).
- Accepts flipped-card results and converts a matching card into a burst of one-cycle advance pulses (p_da) for the current player, hopping over tiles occupied by other chickens.
- A mismatching card passes the turn to the next player, modulo N.

Parameters:
- TRACK, 24, number of tiles; positions wrap TRACK-1 -> 0.
- PW, 5, position width in bits.
- TIMEOUT, 1000, idle cycles before forced turn pass (used only with TURN_TIMEOUT_EN).

Ports:
- B  in  1  system clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- N  in  4  player count; values <2 are treated as 2, values >4 as 4.
- card_valid  in  1  card result present.
- card_match  in  1  1 = card matches the tile ahead of the current player.
- card_ready  out  1  block can accept a card this cycle.
- pos0..pos3  in  PW each  current player positions from the downstream counters.
- p_da  out  4  one-hot advance pulse; bit i goes to player i's counter.
- turn  out  2  index of the current player.
- busy  out  1  high while pulses are being issued or settling.

Behaviour:
- Reset is asynchronous and active-low on rst. Values while rst is low:
  - state = WAIT, turn = 0, p_da = 0, busy = 0, card_ready = 0.
  - Step counter = 0, timeout counter = 0.
  - card_ready rises one cycle after rst deasserts.
- Clocking: single clock B. All outputs are registered.
- Card handshake:
  - A card is accepted on the rising edge where card_valid & card_ready.
  - card_ready = (state == WAIT).
  - card_valid while card_ready is low is ignored; it is not queued.
- States: WAIT, STEP, SETTLE, PASS.
- WAIT, accepted card with card_match = 1:
  - Compute hops = 1 + k, where k is the number of consecutive tiles ahead of pos[turn] (mod TRACK) occupied by other active players (index < Neff).
  - k is at most Neff-1.
  - Latch hops and go to STEP.
- WAIT, accepted card with card_match = 0: go to PASS.
- STEP:
  - p_da[turn] = 1 for exactly hops consecutive cycles; all other bits are 0.
  - The step counter decrements once per cycle.
  - Go to SETTLE after the last pulse.
- SETTLE:
  - One cycle, p_da = 0, so the counters' updated positions are visible.
  - Then return to WAIT with the same turn; a matching player keeps flipping.
- PASS:
  - One cycle; turn = (turn + 1) mod Neff.
  - Then go to WAIT.
- busy = (state == STEP or SETTLE).
- Latency: accepted match to first p_da pulse = 1 cycle. Accepted mismatch to turn change = 1 cycle after PASS is entered.
- Hop arithmetic: (pos + j) mod TRACK, computed at PW+1 bits, then subtract TRACK if the result is >= TRACK.
- Positions are sampled only at card acceptance. Changes to pos* during STEP do not affect the hop count.
- N changes mid-turn:
  - Neff is re-evaluated every cycle.
  - If turn >= Neff while in WAIT, turn is forced to 0 on the next edge.
- Reset mid-STEP: pulses stop immediately (p_da = 0 asynchronously) and the hop burst is abandoned.
- pos values >= TRACK are treated as unoccupied when computing hops.

Optional Feature:
- Macro: TURN_TIMEOUT_EN.
- Defined:
  - A counter increments on every cycle spent in WAIT and clears on any accepted card.
  - When it reaches TIMEOUT, the block enters PASS as if a mismatch had been accepted, and the counter clears.
  - Simultaneous timeout and accepted card: the card wins.
- Undefined: no counter exists; WAIT holds indefinitely.

Decomposition:
- Shared package, chicken_pkg:
  - Constants TRACK_LEN = 24, POS_W = 5, MAX_PLAYERS = 4.
  - State encoding for turn_ctrl: WAIT = 2'd0, STEP = 2'd1, SETTLE = 2'd2, PASS = 2'd3.
- One natural sub-module, hop_calc: purely combinational; inputs (pos array, turn, Neff); output hops (3 bits).
- The FSM and counters remain in turn_ctrl.

Test Plan:
1. N=2, pos0=0, pos1=12, card_match=1 -> p_da=0001 for 1 cycle, turn stays 0, card_ready returns after SETTLE.
2. N=4, pos0=5, pos1=6, pos2=7, pos3=20, card_match=1 on turn 0 -> p_da=0001 for 3 consecutive cycles (hops=3), then SETTLE.
3. N=3, turn=2, card_match=0 -> turn becomes 0 (wrap mod 3); p_da stays 0.
4. Wrap: N=2, pos0=23, pos1=0, match on turn 0 -> hops=2, two pulses on p_da[0].
5. rst low during the second of three STEP pulses -> p_da=0 immediately, turn=0, state=WAIT; card_ready=1 one cycle after rst releases.
6. With TURN_TIMEOUT_EN and TIMEOUT=8, no card for 8 cycles in WAIT -> turn advances by 1. Card_valid arriving on the same cycle as the timeout -> the card is processed and the turn does not advance.
